shake_arbiter: RTL

- Round-robin scheduler that shares one SHAKE256 absorb/squeeze core between N_REQ requesters.
- Grants the core to one requester for a whole message, streams its rate blocks into the core, then issues the requested number of squeeze permutations.
- Returns each 1088-bit output block, tagged with the requester id, on a valid/ready output channel.
- Sits between the message producers and the core; it is the only block that drives the core's load/squeeze controls.

---
 rtl/shake_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/shake_arbiter.sv
// rtl/shake_arbiter.sv - round-robin scheduler sharing one SHAKE256 absorb/squeeze core
// Grants the core for a whole message, then squeezes and returns the requested output blocks.
module shake_arbiter #(
  parameter int N_REQ  = 2,
  parameter int RATE   = 1088,
  parameter int LEN_W  = 11,
  parameter int NOUT_W = 4,
  parameter int ID_W   = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*RATE-1:0]     req_msg,
  input  logic [N_REQ*LEN_W-1:0]    req_len,
  input  logic [N_REQ-1:0]          req_last,
  input  logic [N_REQ*NOUT_W-1:0]   req_nout,
  output logic [N_REQ-1:0]          req_ready,
  output logic [RATE-1:0]           core_msg,
  output logic [LEN_W-1:0]          core_len,
  output logic                      core_load,
  output logic                      core_squeeze,
  input  logic                      core_busy,
  input  logic                      core_done,
  input  logic [RATE-1:0]           core_hash,
  output logic                      out_valid,
  output logic [RATE-1:0]           out_data,
  output logic [ID_W-1:0]           out_id,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic                      grant_busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_ABS, OUT, SQZ, WAIT_SQZ} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    rr_q, rr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic                first_q, first_d;
  logic                last_q, last_d;
  logic [NOUT_W-1:0]   nout_q, nout_d;
  logic [NOUT_W-1:0]   count_q, count_d;
  logic                out_valid_q, out_valid_d;
  logic [RATE-1:0]     out_data_q, out_data_d;
  logic [ID_W-1:0]     out_id_q, out_id_d;
  logic                out_last_q, out_last_d;

  logic [RATE-1:0]     sel_msg;
  logic [LEN_W-1:0]    sel_len;
  logic [NOUT_W-1:0]   sel_nout;
  logic                sel_valid;
  logic                sel_last;
  logic [PTR_W-1:0]    pick_idx;
  logic                xfer;
  logic                capture;

  always_comb begin
    sel_msg   = req_msg[int'(owner_q)*RATE +: RATE];
    sel_len   = req_len[int'(owner_q)*LEN_W +: LEN_W];
    sel_nout  = req_nout[int'(owner_q)*NOUT_W +: NOUT_W];
    sel_valid = req_valid[owner_q];
    sel_last  = req_last[owner_q];
    xfer      = (state_q == LOAD) && sel_valid && !core_busy;
    capture   = core_done && (((state_q == WAIT_ABS) && last_q) || (state_q == WAIT_SQZ));
  end

  // Scan downward so the smallest offset from the rr pointer wins.
  always_comb begin
    pick_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[(int'(rr_q) + i) % N_REQ]) begin
        pick_idx = PTR_W'((int'(rr_q) + i) % N_REQ);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (|req_valid) state_d = LOAD;
      LOAD:     if (xfer) state_d = WAIT_ABS;
      WAIT_ABS: if (core_done) state_d = last_q ? OUT : LOAD;
      OUT:      if (out_ready) state_d = out_last_q ? IDLE : SQZ;
      SQZ:      if (!core_busy) state_d = WAIT_SQZ;
      WAIT_SQZ: if (core_done) state_d = OUT;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready          = '0;
    req_ready[owner_q] = xfer;
    core_load          = xfer;
    core_msg           = (state_q == LOAD) ? sel_msg : '0;
    core_len           = (state_q == LOAD) ? sel_len : '0;
    core_squeeze       = (state_q == SQZ) && !core_busy;
    grant_busy         = (state_q != IDLE);
    out_valid          = out_valid_q;
    out_data           = out_data_q;
    out_id             = out_id_q;
    out_last           = out_last_q;
  end

  always_comb begin
    rr_d        = rr_q;
    owner_d     = owner_q;
    first_d     = first_q;
    last_d      = last_q;
    nout_d      = nout_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_last_d  = out_last_q;
    if ((state_q == IDLE) && (|req_valid)) begin
      owner_d = pick_idx;
      first_d = 1'b1;
      count_d = '0;
    end
    if (xfer) begin
      last_d  = sel_last;
      first_d = 1'b0;
      // A zero count still yields one output block.
      if (first_q) nout_d = (sel_nout == '0) ? NOUT_W'(1) : sel_nout;
    end
    if (capture) begin
      out_valid_d = 1'b1;
      out_data_d  = core_hash;
      out_id_d    = ID_W'(owner_q);
      out_last_d  = (count_q == nout_q - NOUT_W'(1));
    end
    if ((state_q == OUT) && out_ready) begin
      out_valid_d = 1'b0;
      count_d     = count_q + NOUT_W'(1);
      if (out_last_q) rr_d = PTR_W'((int'(owner_q) + 1) % N_REQ);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_q        <= '0;
      owner_q     <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      nout_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_last_q  <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      first_q     <= first_d;
      last_q      <= last_d;
      nout_q      <= nout_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule
